// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable divider: NUM_CH independent square waves and period ticks from clk.
// Optional macro CLK_DIV_SYNC_RELOAD_EN defers divisor writes on running channels to the period wrap.
module clock_divider_multi #(
    parameter  int NUM_CH  = 2,
    parameter  int CNT_W   = 8,
    parameter  int DEF_DIV = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d;
        logic             clk_q, clk_d, tick_q, tick_d, run_q, run_d;
        logic             wr_hit, wrap, restart;
`ifdef CLK_DIV_SYNC_RELOAD_EN
        logic             pend_v_q, pend_v_d, keep;
        logic [CNT_W-1:0] pend_q, pend_d;
`endif

        // Out-of-range wr_ch never equals a valid channel index, so such writes drop out here.
        assign wr_hit = wr_en && (32'(wr_ch) == 32'(i));
        assign wrap   = (cnt_q == div_q - CNT_W'(1));

        always_comb begin
            div_d   = div_q;
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            run_d   = 1'b0;
            restart = 1'b0;
`ifdef CLK_DIV_SYNC_RELOAD_EN
            pend_v_d = pend_v_q;
            pend_d   = pend_q;
            if (wr_hit) begin
                pend_v_d = 1'b1;
                pend_d   = wr_div;
            end
            keep = run_q && enable && ch_en[i] && (div_q != '0);
            // A channel that is not continuing takes the new divisor straight away.
            if (!keep || wrap) begin
                if (pend_v_d) begin
                    div_d   = pend_d;
                    restart = 1'b1;
                end
                pend_v_d = 1'b0;
            end
`else
            if (wr_hit) begin
                div_d   = wr_div;
                restart = 1'b1;
            end
`endif
            if (enable && ch_en[i] && (div_d != '0)) begin
                run_d = 1'b1;
                if (restart || !run_q || wrap)
                    cnt_d = '0;
                else
                    cnt_d = cnt_q + CNT_W'(1);
                // High for the first div - div/2 counts, so odd divisors run high-long.
                clk_d  = (cnt_d < (div_d - (div_d >> 1)));
                tick_d = (cnt_d == '0);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                div_q  <= CNT_W'(DEF_DIV);
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                run_q  <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                run_q  <= run_d;
            end
        end

`ifdef CLK_DIV_SYNC_RELOAD_EN
        always_ff @(posedge clk) begin
            if (reset) begin
                pend_v_q <= 1'b0;
                pend_q   <= '0;
            end else begin
                pend_v_q <= pend_v_d;
                pend_q   <= pend_d;
            end
        end
`endif

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign running[i] = run_q;
    end

endmodule
